instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
Writer side of the instruction memory. It receives a program as a byte stream over a valid/ready handshake, assembles the bytes into instruction words, and drives a synchronous write port into instruction storage starting at address 0. While loading it holds the CPU in reset, then raises done. It lets the machine be reprogrammed without editing the memory initialisation.

Parameters:
INSTRUCTION_SIZE, 16, instruction word width in bits; must be a multiple of 8.
INSTRUCTION_ADDR_SIZE, 10, instruction address width; memory depth is 1 << INSTRUCTION_ADDR_SIZE.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader accepts a byte this cycle; transfer happens when in_valid && in_ready.
mem_we  output  1  write strobe to instruction memory, one cycle per word.
mem_addr  output  INSTRUCTION_ADDR_SIZE  write address.
mem_data  output  INSTRUCTION_SIZE  write data.
busy  output  1  load in progress.
cpu_hold  output  1  holds the CPU in reset; equal to busy.
done  output  1  last load completed successfully; sticky until the next start.
error  output  1  last load was rejected for length overflow; sticky until the next start.

Behaviour:
- Reset (asynchronous): state IDLE. in_ready=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, cpu_hold=0, done=0, error=0. Internal word count, byte index and shift register are cleared.
- Stream format: a 16-bit big-endian length N (number of words), followed by N words. Each word is INSTRUCTION_SIZE/8 bytes, most significant byte first.
- IDLE / DONE:
  - in_ready=0.
  - On start: clear done and error, set busy, go to LEN_HI.
- LEN_HI -> LEN_LO: each state accepts one byte (in_ready=1).
- After LEN_LO:
  - N == 0: go to DONE with done=1 and no writes.
  - N > (1 << INSTRUCTION_ADDR_SIZE): go to DONE with error=1 and no writes. The payload is not consumed; the sender must reset or restart.
  - Otherwise: go to DATA with mem_addr=0.
- DATA:
  - in_ready=1. Each accepted byte shifts into the word register from the LSB side.
  - When the last byte of a word is accepted, go to WRITE on the next edge.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1, mem_data=assembled word, mem_addr=current address.
  - Next edge: address increments. If the written word was word N, go to DONE with done=1; otherwise return to DATA.
- Latency: mem_we rises in the cycle after the final byte of a word is accepted. Minimum per-word cost is INSTRUCTION_SIZE/8 + 1 cycles.
- Stalls: in_valid=0 in any accepting state holds all state; there is no timeout.
- Ignored inputs: bytes presented while in_ready=0 are not consumed. start is ignored while busy.
- mem_addr and mem_data hold their values between writes.
- Address arithmetic: the counter is INSTRUCTION_ADDR_SIZE+1 bits wide internally so that N equal to full depth completes without wrap. mem_addr carries the low bits, and the last write goes to address (1<<INSTRUCTION_ADDR_SIZE)-1.
- busy=1 in every state except IDLE and DONE. done=1 and error=1 never occur together.
- Reset mid-load: returns to IDLE immediately, and mem_we drops asynchronously. Words already written remain in memory; done stays 0.
- Restart from DONE is allowed and overwrites from address 0.

Decomposition:
- Shared package: the state encoding (IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE) and the constant BYTES_PER_WORD = INSTRUCTION_SIZE/8.
- No sub-module; byte assembly and sequencing are one FSM with a datapath.
- Instruction memory gains a write port (we/waddr/wdata on clk) that this block drives. The loader itself never reads memory.

Test Plan:
- Basic load: start, stream 00 02 | 81 01 | 82 01 with in_valid held high -> writes addr0=0x8101 then addr1=0x8201. mem_we pulses exactly 2 cycles, each 1 cycle after the word's second byte. done=1, busy=0, cpu_hold=0.
- Backpressure and gaps: same stream with in_valid toggled every other cycle -> identical writes. No byte is lost or duplicated across WRITE cycles where in_ready=0.
- Zero length: start, 00 00 -> no mem_we, done=1 two byte-accepts after start.
- Overflow: start, 04 01 (N=1025, depth 1024) -> no mem_we, error=1, done=0, in_ready=0.
- Full depth: N=1024 of incrementing words -> last write addr=1023 with data 0x03FF, done=1, no write to addr 0 after wrap.
- Reset mid-load: assert rst after the first word is written, during the second word's high byte -> outputs return to reset values immediately. Memory addr0 keeps the first word. A following start and a 1-word load writes addr0 again.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and
// byte/word geometry helpers.
package instruction_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_e;

  localparam int DEFAULT_INSTRUCTION_SIZE = 16;
  localparam int BYTES_PER_WORD           = DEFAULT_INSTRUCTION_SIZE / 8;

  // Bytes per instruction word for an arbitrary (multiple-of-8) width.
  function automatic int bytes_per_word(input int size);
    return size / 8;
  endfunction

endpackage

// File: rtl/instruction_loader.sv
// Instruction loader: writer side of the instruction memory.
// Receives a byte stream (16-bit big-endian word count N, then N words
// MSB-first), assembles words and writes them from address 0 upward.
// The CPU is held in reset while a load is in progress.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle load request (honoured in IDLE/DONE only)
//   in_data/valid   stream byte and its qualifier
//   in_ready        loader accepts a byte this cycle
//   mem_we/addr/data synchronous write port into instruction memory
//   busy, cpu_hold  load in progress (identical)
//   done, error     sticky status of the last load
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int INSTRUCTION_SIZE      = 16,
  parameter int INSTRUCTION_ADDR_SIZE = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [7:0]                       in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             mem_we,
  output logic [INSTRUCTION_ADDR_SIZE-1:0] mem_addr,
  output logic [INSTRUCTION_SIZE-1:0]      mem_data,
  output logic                             busy,
  output logic                             cpu_hold,
  output logic                             done,
  output logic                             error
);

  localparam int     BPW   = bytes_per_word(INSTRUCTION_SIZE);
  localparam int     IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  // One extra bit so a full-depth load reaches the final count without wrap.
  localparam int     CNT_W = INSTRUCTION_ADDR_SIZE + 1;
  localparam longint DEPTH = longint'(1) << INSTRUCTION_ADDR_SIZE;

  state_e                      state, state_nxt;
  logic [15:0]                 len_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [IDX_W-1:0]            idx_q;
  logic [INSTRUCTION_SIZE-1:0] shift_q;
  logic [INSTRUCTION_SIZE-1:0] data_q;
  logic                        done_q;
  logic                        error_q;

  logic                        accept;
  logic [15:0]                 len_full;
  logic                        len_zero;
  logic                        len_over;
  logic                        last_byte;
  logic                        last_word;
  logic [INSTRUCTION_SIZE-1:0] shift_nxt;

  always_comb begin
    len_full  = {len_q[15:8], in_data};
    len_zero  = (len_full == 16'd0);
    len_over  = (longint'(len_full) > DEPTH);
    // Bytes enter at the LSB; after BPW shifts the first byte sits at the MSB.
    shift_nxt = (shift_q << 8) | INSTRUCTION_SIZE'(in_data);
    last_byte = (idx_q == IDX_W'(BPW - 1));
    last_word = ((32'(cnt_q) + 32'd1) == 32'(len_q));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and decoded outputs. mem_we is decoded from state so it
  // drops the moment reset forces IDLE.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE, S_DONE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (len_zero || len_over) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid && last_byte) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        state_nxt = last_word ? S_DONE : S_DATA;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign accept = in_valid && in_ready;

  // Datapath: length capture, byte assembly, address count, sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (accept) len_q[15:8] <= in_data;
        end
        S_LEN_LO: begin
          if (accept) begin
            len_q <= len_full;
            if (len_zero) begin
              done_q <= 1'b1;
            end else if (len_over) begin
              error_q <= 1'b1;
            end else begin
              cnt_q <= '0;
              idx_q <= '0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            shift_q <= shift_nxt;
            if (last_byte) begin
              data_q <= shift_nxt;
              idx_q  <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_WRITE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_word) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = cnt_q[INSTRUCTION_ADDR_SIZE-1:0];
  assign mem_data = data_q;
  assign cpu_hold = busy;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader. A reference model derives the
// expected write sequence and final status from the stream contents; a
// monitor records every memory write the DUT performs.
module tb_instruction_loader;

  localparam int IS    = 16;
  localparam int AS    = 10;
  localparam int BPW   = IS / 8;
  localparam int DEPTH = 1 << AS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AS-1:0] mem_addr;
  logic [IS-1:0] mem_data;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;

  logic [AS-1:0] got_addr[$];
  logic [IS-1:0] got_data[$];
  logic [IS-1:0] mem_model[DEPTH];

  instruction_loader #(.INSTRUCTION_SIZE(IS), .INSTRUCTION_ADDR_SIZE(AS)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Behaves as the instruction memory write port and logs each write.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_data);
      mem_model[mem_addr] = mem_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present bytes in order; mode 0 = valid always, 1 = every other cycle,
  // 2 = random. Checks mem_we in the cycle after each word's final byte.
  task automatic send_bytes(input logic [7:0] bytes[$], input int mode,
                            output bit timeout);
    int  k = 0;
    int  cyc = 0;
    bit  tog = 1'b0;
    bit  acc;
    bit  expect_we = 1'b0;
    timeout = 1'b0;
    while (k < bytes.size()) begin
      in_data = bytes[k];
      case (mode)
        0:       in_valid = 1'b1;
        1:       begin in_valid = tog; tog = !tog; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (expect_we) begin
        checks++;
        if (mem_we !== 1'b1) begin
          errors++;
          $display("FAIL we_latency: byte %0d mem_we=%b required 1", k, mem_we);
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      expect_we = acc && (k >= 2) && (((k - 2) % BPW) == BPW - 1);
      if (acc) k++;
      cyc++;
      if (cyc > 20000) begin timeout = 1'b1; break; end
    end
    in_valid = 1'b0;
    if (expect_we) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1) begin
        errors++;
        $display("FAIL we_latency: final word mem_we=%b required 1", mem_we);
      end
    end
  endtask

  // Full load scenario against the reference model.
  task automatic test_load(input string name, input int n, input logic [IS-1:0] words[$],
                           input int mode);
    logic [7:0]    bytes[$];
    logic [IS-1:0] exp_data[$];
    bit            exp_done, exp_err, to;
    bytes.push_back(8'(n >> 8));
    bytes.push_back(8'(n));
    exp_done = (n <= DEPTH);
    exp_err  = (n > DEPTH);
    if (n >= 1 && n <= DEPTH) begin
      for (int w = 0; w < n; w++) begin
        exp_data.push_back(words[w]);
        for (int b = BPW - 1; b >= 0; b--) bytes.push_back(8'(words[w] >> (8 * b)));
      end
    end
    pulse_start();
    got_addr.delete();
    got_data.delete();
    send_bytes(bytes, mode, to);
    @(negedge clk);
    checks++;
    if (to) begin errors++; $display("FAIL %s_timeout: stream not consumed", name); end
    checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL %s_busy: busy=%b cpu_hold=%b required 0 0", name, busy, cpu_hold);
    end
    checks++;
    if (done !== exp_done || error !== exp_err) begin
      errors++;
      $display("FAIL %s_status: done=%b error=%b required %b %b", name, done, error, exp_done, exp_err);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_ready: in_ready=%b required 0", name, in_ready); end
    checks++;
    if (got_addr.size() != exp_data.size()) begin
      errors++;
      $display("FAIL %s_count: writes=%0d required %0d", name, got_addr.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== AS'(i) || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL %s_write%0d: addr=%0d data=%h required %0d %h",
                 name, i, got_addr[i], got_data[i], i, exp_data[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #13;
    checks++;
    if ({in_ready, mem_we, busy, cpu_hold, done, error} !== 6'b0 ||
        mem_addr !== '0 || mem_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b we=%b busy=%b hold=%b done=%b err=%b addr=%0d data=%h required zeros",
               in_ready, mem_we, busy, cpu_hold, done, error, mem_addr, mem_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL idle_outputs: busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [IS-1:0] w[$] = '{16'h8101, 16'h8201};
    test_load("basic", 2, w, 0);
  endtask

  task automatic test_backpressure();
    logic [IS-1:0] w[$] = '{16'h8101, 16'h8201};
    test_load("gaps", 2, w, 1);
  endtask

  task automatic test_zero_len();
    logic [IS-1:0] w[$];
    test_load("zero", 0, w, 0);
  endtask

  task automatic test_overflow();
    logic [IS-1:0] w[$];
    test_load("overflow", DEPTH + 1, w, 0);
  endtask

  task automatic test_full_depth();
    logic [IS-1:0] w[$];
    for (int i = 0; i < DEPTH; i++) w.push_back(IS'(i));
    test_load("full", DEPTH, w, 0);
  endtask

  task automatic test_reset_midload();
    logic [7:0]    bytes[$] = '{8'h00, 8'h02, 8'hC3, 8'h5A};
    logic [IS-1:0] w[$] = '{16'h1234};
    bit to;
    pulse_start();
    send_bytes(bytes, 0, to);
    @(posedge clk); #1;
    in_data  = 8'hAA;
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, mem_we, busy, cpu_hold, done, error} !== 6'b0 ||
        mem_addr !== '0 || mem_data !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%b we=%b busy=%b done=%b addr=%0d data=%h required zeros",
               in_ready, mem_we, busy, done, mem_addr, mem_data);
    end
    in_valid = 1'b0;
    #10 rst = 1'b0;
    checks++;
    if (mem_model[0] !== 16'hC35A) begin
      errors++; $display("FAIL midreset_mem0: mem[0]=%h required c35a", mem_model[0]);
    end
    test_load("reload", 1, w, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [IS-1:0] w[$];
      int sel = int'($urandom_range(0, 9));
      int n;
      if (sel == 0)      n = 0;
      else if (sel == 1) n = DEPTH + 1 + int'($urandom_range(0, 500));
      else               n = int'($urandom_range(1, 24));
      for (int i = 0; i < n && n <= DEPTH; i++) w.push_back(IS'($urandom));
      test_load("random", n, w, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_overflow();
    test_random();
    test_full_depth();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
